attack_scheduler: RTL and testbench
===================================

Name: attack_scheduler

Overview:
- Sequences the player's attack datapath: turns keyboard request levels into timed NORM/SPEC attack windows with cooldowns.
- Drives the attack renderer's enable, type and animation-frame select.
- Sits between keyboard decode and the attack pixel generator.
- Gates the special attack on a charge counter that normal attacks fill.

Parameters:
- CNT_W, 27, width of the duration/cooldown timer
- NORM_DUR, 12_500_000, normal attack active cycles (>=1)
- SPEC_DUR, 67_108_864, special attack active cycles (>=1)
- NORM_CD, 6_250_000, cooldown cycles after normal (0 allowed)
- SPEC_CD, 25_000_000, cooldown cycles after special (0 allowed)
- FRAME_DIV, 4_194_304, active cycles per animation frame (>=1)
- CHARGE_MAX, 3, completed normal attacks needed to arm special (1..7)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- atk_norm_req  in  1  normal-attack key level
- atk_spec_req  in  1  special-attack key level
- atk_active  out  1  attack window open (renderer enable)
- atk_type  out  2  00 none, 01 normal, 10 special
- atk_frame  out  3  animation frame index
- atk_start  out  1  one-cycle pulse, first active cycle
- atk_done  out  1  one-cycle pulse, first cycle after active window
- atk_reject  out  1  one-cycle pulse, request edge dropped
- cooling  out  1  high during COOL
- charge  out  3  current special charge, 0..CHARGE_MAX

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; charge 0; timer 0; edge registers 0.
- Edge detect: req_d registered each cycle. An edge is req && !req_d. Held keys never retrigger.
- States: IDLE, NORM, SPEC, COOL.
- IDLE, spec edge with charge==CHARGE_MAX: next cycle SPEC, charge cleared to 0, atk_start=1.
- IDLE, spec edge with charge<CHARGE_MAX: atk_reject=1, stay IDLE. A normal edge in the same cycle is then accepted.
- IDLE, norm edge only: next cycle NORM, atk_start=1.
- IDLE, both edges and special armed: SPEC wins; the normal edge is dropped without a reject.
- Latency: edge at cycle N gives atk_active=1 and atk_start=1 at cycle N+1.
- NORM/SPEC: timer counts 0..DUR-1. atk_active=1. atk_type=01 or 10.
- atk_frame = (timer / FRAME_DIV) mod 8.
- On timer==DUR-1: go to COOL, or to IDLE if that type's CD==0. Timer reset to 0. atk_done=1 on the following cycle.
- A NORM window ending increments charge, saturating at CHARGE_MAX.
- COOL: cooling=1, atk_type=00, atk_frame=0. Counts CD cycles, then IDLE.
- Any request edge seen in NORM, SPEC or COOL gives atk_reject=1 and is otherwise dropped (unless queued, see the optional feature).
- Timer arithmetic is unsigned CNT_W bits. DUR and CD must fit in CNT_W bits; no wrap occurs in legal configurations.
- Reset mid-attack: immediate IDLE, no atk_done pulse, charge lost.

Optional Feature:
- ATTACK_QUEUE_EN defined: one-deep pending slot.
- A normal edge during NORM/SPEC/COOL is stored instead of rejected; a second edge while the slot is full is rejected.
- On the cycle COOL exits (or the active window exits with CD==0), a pending normal issues NORM directly and the slot clears. atk_start pulses as usual.
- Pending special requests are never queued.
- ATTACK_QUEUE_EN undefined: no slot; all busy-time edges are rejected.

Test Plan:
(All with NORM_DUR=4, SPEC_DUR=8, NORM_CD=2, SPEC_CD=3, FRAME_DIV=2, CHARGE_MAX=2.)
- Reset then norm edge at cycle 10 -> atk_start at 11, atk_active 11..14, atk_frame 0,0,1,1, atk_done at 15, cooling 15..16, IDLE at 17, charge=1.
- Spec edge with charge=0 -> atk_reject pulse, atk_active stays 0. Two completed normals then spec edge -> SPEC for 8 cycles, frames 0..3, charge=0, cooling 3 cycles.
- Charge=2, both edges same cycle -> SPEC only, no atk_reject, no NORM afterwards.
- Norm edge during COOL -> atk_reject=1 (queue off). With ATTACK_QUEUE_EN: no reject, NORM starts the cycle after COOL ends. A second busy edge -> reject.
- Key held high 40 cycles -> exactly one attack.
- rst=0 asserted mid-SPEC -> outputs 0 immediately, charge 0, no atk_done. After release, IDLE accepts a norm edge normally.

Source files
------------

// File: rtl/attack_scheduler.sv
// attack_scheduler: turns key request edges into timed NORM/SPEC attack windows with cooldown and special charge.
// Optional one-deep normal-attack queue when ATTACK_QUEUE_EN is defined.
module attack_scheduler #(
  parameter int CNT_W      = 27,
  parameter int NORM_DUR   = 12_500_000,
  parameter int SPEC_DUR   = 67_108_864,
  parameter int NORM_CD    = 6_250_000,
  parameter int SPEC_CD    = 25_000_000,
  parameter int FRAME_DIV  = 4_194_304,
  parameter int CHARGE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       atk_norm_req,
  input  logic       atk_spec_req,
  output logic       atk_active,
  output logic [1:0] atk_type,
  output logic [2:0] atk_frame,
  output logic       atk_start,
  output logic       atk_done,
  output logic       atk_reject,
  output logic       cooling,
  output logic [2:0] charge
);
  typedef enum logic [1:0] {IDLE, NORM, SPEC, COOL} state_t;
  localparam logic [CNT_W-1:0] NORM_LAST  = CNT_W'(NORM_DUR - 1);
  localparam logic [CNT_W-1:0] SPEC_LAST  = CNT_W'(SPEC_DUR - 1);
  localparam logic [CNT_W-1:0] NCD_LOAD   = CNT_W'(NORM_CD > 0 ? NORM_CD - 1 : 0);
  localparam logic [CNT_W-1:0] SCD_LOAD   = CNT_W'(SPEC_CD > 0 ? SPEC_CD - 1 : 0);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [2:0]       CMAX       = 3'(CHARGE_MAX);
  state_t state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt, fcnt;
  logic [2:0] frame, charge_nxt;
  logic norm_d, spec_d, norm_edge, spec_edge, busy;
  logic pend, pend_nxt, q_take, q_ready;
  logic start_nxt, done_nxt, reject_nxt;
  assign norm_edge = atk_norm_req & ~norm_d;
  assign spec_edge = atk_spec_req & ~spec_d;
  assign busy      = state != IDLE;
`ifdef ATTACK_QUEUE_EN
  assign q_take = busy & norm_edge & ~pend;
`else
  assign q_take = 1'b0;
`endif
  assign q_ready = pend | q_take;
  // COOL counts the timer down from CD-1 so the cooldown length needs no memory of the attack type
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer + CNT_W'(1);
    charge_nxt = charge;
    pend_nxt   = pend | q_take;
    start_nxt  = 1'b0;
    done_nxt   = 1'b0;
    reject_nxt = busy & (spec_edge | (norm_edge & ~q_take));
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (spec_edge && charge == CMAX) begin
          state_nxt  = SPEC;
          charge_nxt = '0;
          start_nxt  = 1'b1;
        end else begin
          reject_nxt = spec_edge;
          state_nxt  = norm_edge ? NORM : IDLE;
          start_nxt  = norm_edge;
        end
      end
      NORM: if (timer == NORM_LAST) begin
        charge_nxt = (charge == CMAX) ? charge : charge + 3'd1;
        done_nxt   = 1'b1;
        timer_nxt  = NCD_LOAD;
        state_nxt  = COOL;
        if (NORM_CD == 0) begin
          timer_nxt = '0;
          state_nxt = q_ready ? NORM : IDLE;
          start_nxt = q_ready;
          pend_nxt  = 1'b0;
        end
      end
      SPEC: if (timer == SPEC_LAST) begin
        done_nxt  = 1'b1;
        timer_nxt = SCD_LOAD;
        state_nxt = COOL;
        if (SPEC_CD == 0) begin
          timer_nxt = '0;
          state_nxt = q_ready ? NORM : IDLE;
          start_nxt = q_ready;
          pend_nxt  = 1'b0;
        end
      end
      COOL: begin
        timer_nxt = timer - CNT_W'(1);
        if (timer == '0) begin
          timer_nxt = '0;
          state_nxt = q_ready ? NORM : IDLE;
          start_nxt = q_ready;
          pend_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      fcnt       <= '0;
      frame      <= '0;
      charge     <= '0;
      norm_d     <= 1'b0;
      spec_d     <= 1'b0;
      pend       <= 1'b0;
      atk_start  <= 1'b0;
      atk_done   <= 1'b0;
      atk_reject <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      charge     <= charge_nxt;
      norm_d     <= atk_norm_req;
      spec_d     <= atk_spec_req;
      pend       <= pend_nxt;
      atk_start  <= start_nxt;
      atk_done   <= done_nxt;
      atk_reject <= reject_nxt;
      if (start_nxt || !(state_nxt == NORM || state_nxt == SPEC)) begin
        fcnt  <= '0;
        frame <= '0;
      end else if (fcnt == FRAME_LAST) begin
        fcnt  <= '0;
        frame <= frame + 3'd1;
      end else begin
        fcnt <= fcnt + CNT_W'(1);
      end
    end
  end
  assign atk_active = (state == NORM) || (state == SPEC);
  assign atk_type   = {state == SPEC, state == NORM};
  assign atk_frame  = frame;
  assign cooling    = state == COOL;
endmodule

// File: tb/tb_attack_scheduler.sv
// tb_attack_scheduler: directed checks of attack_scheduler with short durations; honours ATTACK_QUEUE_EN.
module tb_attack_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic nr = 1'b0;
  logic sr = 1'b0;
  logic atk_active, atk_start, atk_done, atk_reject, cooling;
  logic [1:0] atk_type;
  logic [2:0] atk_frame, charge;
  int checks = 0;
  int errors = 0;
`ifdef ATTACK_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  always #5 clk = ~clk;

  attack_scheduler #(
    .CNT_W(8), .NORM_DUR(4), .SPEC_DUR(8), .NORM_CD(2), .SPEC_CD(3), .FRAME_DIV(2), .CHARGE_MAX(2)
  ) dut (
    .clk(clk), .rst(rst), .atk_norm_req(nr), .atk_spec_req(sr),
    .atk_active(atk_active), .atk_type(atk_type), .atk_frame(atk_frame),
    .atk_start(atk_start), .atk_done(atk_done), .atk_reject(atk_reject),
    .cooling(cooling), .charge(charge)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_norm;
    nr = 1'b1;
    step();
    nr = 1'b0;
    repeat (6) step();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((atk_active || cooling) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (atk_active || cooling) begin
      errors++;
      $display("FAIL %s idle timeout: active=%b cooling=%b want 0 0", name, atk_active, cooling);
    end
  endtask

  task automatic test_reset;
    repeat (2) step();
    checks++;
    if ({atk_active, atk_type, atk_frame, atk_start, atk_done, atk_reject, cooling, charge} !== 14'd0) begin
      errors++;
      $display("FAIL reset outputs got %b want 0", {atk_active, atk_type, atk_frame, atk_start, atk_done, atk_reject, cooling, charge});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({atk_active, atk_start, atk_reject, cooling, charge} !== 7'd0) begin
      errors++;
      $display("FAIL reset release got %b want 0", {atk_active, atk_start, atk_reject, cooling, charge});
    end
  endtask

  task automatic test_spec_reject;
    sr = 1'b1;
    step();
    sr = 1'b0;
    checks++;
    if ({atk_reject, atk_active, atk_start} !== 3'b100) begin
      errors++;
      $display("FAIL spec_reject k1 got %b want 100", {atk_reject, atk_active, atk_start});
    end
    step();
    checks++;
    if ({atk_reject, atk_active, charge} !== 5'b0) begin
      errors++;
      $display("FAIL spec_reject k2 got %b want 0", {atk_reject, atk_active, charge});
    end
  endtask

  task automatic test_norm;
    logic [7:0] e_act, e_start, e_done, e_cool, e_fr;
    logic [9:0] obs, exp;
    e_act = 8'b0001_1110;
    e_start = 8'b0000_0010;
    e_done = 8'b0010_0000;
    e_cool = 8'b0110_0000;
    e_fr = 8'b0001_1000;
    nr = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) nr = 1'b0;
      exp = {e_act[k], e_act[k] ? 2'b01 : 2'b00, 2'b00, e_fr[k], e_start[k], e_done[k], 1'b0, e_cool[k]};
      obs = {atk_active, atk_type, atk_frame, atk_start, atk_done, atk_reject, cooling};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL norm k=%0d {act,type,frame,start,done,rej,cool} got %b want %b", k, obs, exp);
      end
    end
    checks++;
    if (charge !== 3'd1) begin
      errors++;
      $display("FAIL norm charge got %0d want 1", charge);
    end
  endtask

  task automatic spec_window(input string name);
    logic [12:0] e_act, e_start, e_done, e_cool;
    logic [9:0] obs, exp;
    e_act = 13'h1FE;
    e_start = 13'h002;
    e_done = 13'h200;
    e_cool = 13'hE00;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) begin
        nr = 1'b0;
        sr = 1'b0;
      end
      exp = {e_act[k], e_act[k] ? 2'b10 : 2'b00, (k <= 8) ? 3'((k - 1) / 2) : 3'd0,
             e_start[k], e_done[k], 1'b0, e_cool[k]};
      obs = {atk_active, atk_type, atk_frame, atk_start, atk_done, atk_reject, cooling};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s k=%0d {act,type,frame,start,done,rej,cool} got %b want %b", name, k, obs, exp);
      end
      if (k == 1) begin
        checks++;
        if (charge !== 3'd0) begin
          errors++;
          $display("FAIL %s charge got %0d want 0", name, charge);
        end
      end
    end
  endtask

  task automatic test_spec;
    run_norm();
    checks++;
    if (charge !== 3'd2) begin
      errors++;
      $display("FAIL spec armed charge got %0d want 2", charge);
    end
    sr = 1'b1;
    spec_window("spec");
  endtask

  task automatic test_both;
    run_norm();
    run_norm();
    nr = 1'b1;
    sr = 1'b1;
    spec_window("both");
    repeat (3) begin
      step();
      checks++;
      if ({atk_active, atk_reject} !== 2'b00) begin
        errors++;
        $display("FAIL both trailing {act,rej} got %b want 00", {atk_active, atk_reject});
      end
    end
  endtask

  task automatic test_busy;
    nr = 1'b1;
    step();
    nr = 1'b0;
    checks++;
    if ({atk_active, atk_start} !== 2'b11) begin
      errors++;
      $display("FAIL busy start got %b want 11", {atk_active, atk_start});
    end
    step();
    nr = 1'b1;
    step();
    nr = 1'b0;
    checks++;
    if (atk_reject !== !QUEUE) begin
      errors++;
      $display("FAIL busy first_edge reject got %b want %b", atk_reject, !QUEUE);
    end
    step();
    nr = 1'b1;
    step();
    nr = 1'b0;
    checks++;
    if ({atk_reject, cooling} !== 2'b11) begin
      errors++;
      $display("FAIL busy second_edge {rej,cool} got %b want 11", {atk_reject, cooling});
    end
    step();
    step();
    checks++;
    if ({atk_active, atk_start} !== {QUEUE, QUEUE}) begin
      errors++;
      $display("FAIL busy queued {act,start} got %b want %b", {atk_active, atk_start}, {QUEUE, QUEUE});
    end
    wait_idle("busy");
  endtask

  task automatic test_cool_edge;
    nr = 1'b1;
    step();
    nr = 1'b0;
    repeat (4) step();
    nr = 1'b1;
    checks++;
    if (cooling !== 1'b1) begin
      errors++;
      $display("FAIL cool_edge cooling got %b want 1", cooling);
    end
    step();
    nr = 1'b0;
    checks++;
    if (atk_reject !== !QUEUE) begin
      errors++;
      $display("FAIL cool_edge reject got %b want %b", atk_reject, !QUEUE);
    end
    step();
    checks++;
    if ({atk_active, atk_start, cooling} !== {QUEUE, QUEUE, 1'b0}) begin
      errors++;
      $display("FAIL cool_edge after {act,start,cool} got %b want %b", {atk_active, atk_start, cooling}, {QUEUE, QUEUE, 1'b0});
    end
    wait_idle("cool_edge");
  endtask

  task automatic test_hold;
    int starts = 0;
    int rejects = 0;
    nr = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      starts += int'(atk_start);
      rejects += int'(atk_reject);
    end
    nr = 1'b0;
    checks++;
    if (starts != 1 || rejects != 0) begin
      errors++;
      $display("FAIL hold starts=%0d rejects=%0d want 1 0", starts, rejects);
    end
  endtask

  task automatic test_reset_mid;
    checks++;
    if (charge !== 3'd2) begin
      errors++;
      $display("FAIL reset_mid charge got %0d want 2", charge);
    end
    sr = 1'b1;
    step();
    sr = 1'b0;
    step();
    step();
    checks++;
    if (atk_type !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid in spec type got %b want 10", atk_type);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({atk_active, atk_type, atk_frame, atk_start, atk_done, atk_reject, cooling, charge} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid outputs got %b want 0", {atk_active, atk_type, atk_frame, atk_start, atk_done, atk_reject, cooling, charge});
    end
    step();
    step();
    checks++;
    if ({atk_done, atk_active} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid held {done,act} got %b want 00", {atk_done, atk_active});
    end
    rst = 1'b1;
    step();
    nr = 1'b1;
    step();
    nr = 1'b0;
    checks++;
    if ({atk_active, atk_start, atk_type} !== 4'b1101) begin
      errors++;
      $display("FAIL reset_mid restart got %b want 1101", {atk_active, atk_start, atk_type});
    end
    wait_idle("reset_mid");
    checks++;
    if (charge !== 3'd1) begin
      errors++;
      $display("FAIL reset_mid final charge got %0d want 1", charge);
    end
  endtask

  initial begin
    test_reset();
    test_spec_reject();
    test_norm();
    test_spec();
    test_both();
    test_busy();
    test_cool_edge();
    test_hold();
    wait_idle("hold");
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
